unidade_controle_niveis: RTL and testbench
==========================================

// Module: unidade_controle_niveis
// PURPOSE
//  Moore control FSM for the drone game, with multiple levels and multiple lives.
//  Sits above the datapath: drives position reset, timer count/clear and shift strobes.
//  Adds a lives counter and a level counter. Exports the level so the datapath can pick the step period.
// PARAMETERS
//  NUM_VIDAS   3  lives per game (>=1)
//  NUM_NIVEIS  4  levels per game (>=1); the last level cleared -> vitoria
//  W_VIDAS     $clog2(NUM_VIDAS+1)  width of vidas
//  W_NIVEL     $clog2(NUM_NIVEIS)   width of nivel (min 1)
// PORTS
//  clock          in   1        system clock, rising edge
//  reset          in   1        synchronous, active-high
//  iniciar        in   1        start / restart request (level-sensitive)
//  fim_espera     in   1        step timer expired
//  fim_mapa       in   1        map of the current level finished
//  colisao        in   1        collision detected after a shift
//  pausar         in   1        pause toggle pulse (used only with PAUSA_EN)
//  zeraPosicoes   out  1        clear drone/obstacle positions
//  contaT         out  1        enable step timer
//  zeraT          out  1        clear step timer
//  desloca        out  1        shift map one step
//  venceu         out  1        game won
//  perdeu         out  1        game lost
//  nivel          out  W_NIVEL  current level, 0-based (datapath speed select)
//  vidas          out  W_VIDAS  remaining lives
//  db_estado      out  4        debug state code
// BEHAVIOUR
//  All state and counters update on the rising edge of clock. reset wins over every input.
//  reset -> state INICIAL(0), vidas=NUM_VIDAS, nivel=0. Outputs follow the Moore table below.
//  States (code) and next state:
//   INICIAL(0)        iniciar ? PREPARACAO : INICIAL
//   PREPARACAO(1)     -> ESPERA
//   ESPERA(3)         pausar ? PAUSA : fim_espera ? DESLOCAMENTO : ESPERA  (pausar has priority)
//   DESLOCAMENTO(4)   -> CHECA_COLISAO
//   CHECA_COLISAO(5)  colisao ? PERDE_VIDA : PROXIMO
//   PROXIMO(6)        !fim_mapa ? ESPERA : (nivel==NUM_NIVEIS-1 ? VITORIA : PROX_NIVEL)
//   PERDE_VIDA(9)     vidas==1 ? DERROTA : PREPARACAO; vidas-- on this exit edge
//   PROX_NIVEL(10)    -> PREPARACAO; nivel++ on this exit edge
//   DERROTA(7) / VITORIA(8)  iniciar ? PREPARACAO : hold
//   PAUSA(11)         pausar ? ESPERA : PAUSA
//   Illegal codes     -> INICIAL; db_estado=F
//  Counter reload: leaving INICIAL, DERROTA or VITORIA on iniciar loads vidas=NUM_VIDAS, nivel=0.
//  Counters never wrap: vidas reaches 0 only in DERROTA; nivel saturates at NUM_NIVEIS-1.
//  Moore outputs:
//   zeraPosicoes = INICIAL | PREPARACAO
//   zeraT        = INICIAL | PREPARACAO | PROXIMO | PERDE_VIDA | PROX_NIVEL
//   contaT = ESPERA;  desloca = DESLOCAMENTO;  venceu = VITORIA;  perdeu = DERROTA
//   PAUSA asserts no strobes. contaT=0 there, so the timer value is held.
//  Latency: shift to verdict = 2 cycles (DESLOCAMENTO -> CHECA_COLISAO -> next state).
//  Lost life: positions are cleared in PREPARACAO; nivel is kept.
// CONFIGURATION
//  PAUSA_EN defined: PAUSA state and the pausar input are live.
//  PAUSA_EN undefined: pausar is ignored, PAUSA is unreachable, ESPERA uses only fim_espera.
// STRUCTURE
//  Shared package/include unidade_controle_pkg: 4-bit state codes and db_estado codes.
//  One sub-module, contador_vidas_nivel: vidas/nivel registers with load, decrement and
//  saturating increment. The FSM drives its load/dec/inc strobes.
// TESTING
//  1 NUM_VIDAS=3 NUM_NIVEIS=2: iniciar, no colisao, fim_mapa on the 3rd step -> nivel=1;
//    fim_mapa again -> VITORIA, venceu=1, db_estado=8.
//  2 colisao on each verdict -> vidas 3->2->1, PREPARACAO between each; 3rd hit -> DERROTA, perdeu=1, vidas=0.
//  3 In DERROTA pulse iniciar -> PREPARACAO next cycle, vidas=3, nivel=0, zeraPosicoes=1.
//  4 reset pulsed in DESLOCAMENTO -> next cycle INICIAL, all strobes 0, counters reloaded.
//  5 PAUSA_EN: pausar in ESPERA -> PAUSA, contaT=0 while fim_espera held high; pausar -> ESPERA.
//    Without PAUSA_EN the same stimulus never enters PAUSA.
//  6 pausar and fim_espera together in ESPERA -> PAUSA with PAUSA_EN, DESLOCAMENTO without.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// Shared state codes, debug codes and Moore output decode for the drone game control unit.
package unidade_controle_pkg;

  localparam int unsigned W_ESTADO = 4;

  typedef enum logic [W_ESTADO-1:0] {
    INICIAL       = 4'd0,
    PREPARACAO    = 4'd1,
    ESPERA        = 4'd3,
    DESLOCAMENTO  = 4'd4,
    CHECA_COLISAO = 4'd5,
    PROXIMO       = 4'd6,
    DERROTA       = 4'd7,
    VITORIA       = 4'd8,
    PERDE_VIDA    = 4'd9,
    PROX_NIVEL    = 4'd10,
    PAUSA         = 4'd11
  } estado_t;

  localparam logic [W_ESTADO-1:0] DB_ILEGAL = 4'hF;

  typedef struct packed {
    logic                zera_posicoes;
    logic                conta_t;
    logic                zera_t;
    logic                desloca;
    logic                venceu;
    logic                perdeu;
    logic [W_ESTADO-1:0] db_estado;
  } saidas_t;

  // Moore output table, indexed by the state the FSM is about to enter.
  function automatic saidas_t decodifica_saidas(input estado_t e);
    saidas_t s;
    s           = '0;
    s.db_estado = W_ESTADO'(e);
    case (e)
      INICIAL, PREPARACAO: begin
        s.zera_posicoes = 1'b1;
        s.zera_t        = 1'b1;
      end
      PROXIMO, PERDE_VIDA, PROX_NIVEL: s.zera_t  = 1'b1;
      ESPERA:                          s.conta_t = 1'b1;
      DESLOCAMENTO:                    s.desloca = 1'b1;
      VITORIA:                         s.venceu  = 1'b1;
      DERROTA:                         s.perdeu  = 1'b1;
      CHECA_COLISAO, PAUSA:            s.db_estado = W_ESTADO'(e);
      default:                         s.db_estado = DB_ILEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_vidas_nivel.sv
// Lives and level registers: reload on game start, decrement on lost life, saturating level increment.
module contador_vidas_nivel #(
  parameter int unsigned NUM_VIDAS  = 3,
  parameter int unsigned NUM_NIVEIS = 4,
  parameter int unsigned W_VIDAS    = 2,
  parameter int unsigned W_NIVEL    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic               decrementa,
  input  logic               incrementa,
  output logic [W_VIDAS-1:0] vidas,
  output logic [W_NIVEL-1:0] nivel
);

  localparam logic [W_VIDAS-1:0] VIDAS_INI = W_VIDAS'(NUM_VIDAS);
  localparam logic [W_NIVEL-1:0] NIVEL_MAX = W_NIVEL'(NUM_NIVEIS - 1);

  // Neither counter wraps: vidas stops at 0, nivel stops at the last level.
  always_ff @(posedge clock) begin
    if (reset || carrega) begin
      vidas <= VIDAS_INI;
      nivel <= '0;
    end else begin
      if (decrementa && (vidas != '0))
        vidas <= vidas - W_VIDAS'(1);
      if (incrementa && (nivel != NIVEL_MAX))
        nivel <= nivel + W_NIVEL'(1);
    end
  end

endmodule

// File: rtl/unidade_controle_niveis.sv
// Moore control FSM for the multi-level, multi-life drone game.
// Build option: define PAUSA_EN to make the pausar input and the PAUSA state live.
module unidade_controle_niveis
  import unidade_controle_pkg::*;
#(
  parameter  int unsigned NUM_VIDAS  = 3,
  parameter  int unsigned NUM_NIVEIS = 4,
  localparam int unsigned W_VIDAS    = $clog2(NUM_VIDAS + 1),
  localparam int unsigned W_NIVEL    = (NUM_NIVEIS > 1) ? $clog2(NUM_NIVEIS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               fim_espera,
  input  logic               fim_mapa,
  input  logic               colisao,
  input  logic               pausar,
  output logic               zeraPosicoes,
  output logic               contaT,
  output logic               zeraT,
  output logic               desloca,
  output logic               venceu,
  output logic               perdeu,
  output logic [W_NIVEL-1:0] nivel,
  output logic [W_VIDAS-1:0] vidas,
  output logic [3:0]         db_estado
);

  estado_t estado;
  estado_t proximo_c;
  saidas_t saidas;
  logic    carrega_c;
  logic    decrementa_c;
  logic    incrementa_c;

`ifndef PAUSA_EN
  logic unused_pausar;
  assign unused_pausar = pausar;
`endif

  // Counter strobes act on the edge that leaves the corresponding state.
  assign carrega_c    = iniciar && ((estado == INICIAL) || (estado == DERROTA) ||
                                    (estado == VITORIA));
  assign decrementa_c = (estado == PERDE_VIDA);
  assign incrementa_c = (estado == PROX_NIVEL);

  contador_vidas_nivel #(
    .NUM_VIDAS  (NUM_VIDAS),
    .NUM_NIVEIS (NUM_NIVEIS),
    .W_VIDAS    (W_VIDAS),
    .W_NIVEL    (W_NIVEL)
  ) u_contador (
    .clock      (clock),
    .reset      (reset),
    .carrega    (carrega_c),
    .decrementa (decrementa_c),
    .incrementa (incrementa_c),
    .vidas      (vidas),
    .nivel      (nivel)
  );

  // Next-state logic.
  always_comb begin
    proximo_c = estado;
    case (estado)
      INICIAL, DERROTA, VITORIA:
        if (iniciar) proximo_c = PREPARACAO;
      PREPARACAO:
        proximo_c = ESPERA;
      ESPERA: begin
`ifdef PAUSA_EN
        if (pausar)
          proximo_c = PAUSA;
        else if (fim_espera)
          proximo_c = DESLOCAMENTO;
`else
        if (fim_espera)
          proximo_c = DESLOCAMENTO;
`endif
      end
      DESLOCAMENTO:
        proximo_c = CHECA_COLISAO;
      CHECA_COLISAO:
        proximo_c = colisao ? PERDE_VIDA : PROXIMO;
      PROXIMO: begin
        if (!fim_mapa)
          proximo_c = ESPERA;
        else if (nivel == W_NIVEL'(NUM_NIVEIS - 1))
          proximo_c = VITORIA;
        else
          proximo_c = PROX_NIVEL;
      end
      PERDE_VIDA:
        proximo_c = (vidas == W_VIDAS'(1)) ? DERROTA : PREPARACAO;
      PROX_NIVEL:
        proximo_c = PREPARACAO;
      PAUSA: begin
`ifdef PAUSA_EN
        if (pausar) proximo_c = ESPERA;
`else
        proximo_c = INICIAL;
`endif
      end
      default:
        proximo_c = INICIAL;
    endcase
  end

  // State and Moore outputs registered together so outputs never lag the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      saidas <= decodifica_saidas(INICIAL);
    end else begin
      estado <= proximo_c;
      saidas <= decodifica_saidas(proximo_c);
    end
  end

  assign zeraPosicoes = saidas.zera_posicoes;
  assign contaT       = saidas.conta_t;
  assign zeraT        = saidas.zera_t;
  assign desloca      = saidas.desloca;
  assign venceu       = saidas.venceu;
  assign perdeu       = saidas.perdeu;
  assign db_estado    = saidas.db_estado;

endmodule

// File: tb/tb_unidade_controle_niveis.sv
// Bench for unidade_controle_niveis: directed game scenarios plus random play against a game model.
module tb_unidade_controle_niveis;

  localparam int unsigned NV = 3;
  localparam int unsigned NN = 2;
`ifdef PAUSA_EN
  localparam bit PAUSA_ON = 1'b1;
`else
  localparam bit PAUSA_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, iniciar, fim_espera, fim_mapa, colisao, pausar;
  logic       zeraPosicoes, contaT, zeraT, desloca, venceu, perdeu;
  logic [0:0] nivel;
  logic [1:0] vidas;
  logic [3:0] db_estado;

  int n_comp = 0;
  int n_erro = 0;
  int m_est, m_vid, m_niv;

  always #5 clock = ~clock;

  unidade_controle_niveis #(.NUM_VIDAS(NV), .NUM_NIVEIS(NN)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .fim_espera   (fim_espera),
    .fim_mapa     (fim_mapa),
    .colisao      (colisao),
    .pausar       (pausar),
    .zeraPosicoes (zeraPosicoes),
    .contaT       (contaT),
    .zeraT        (zeraT),
    .desloca      (desloca),
    .venceu       (venceu),
    .perdeu       (perdeu),
    .nivel        (nivel),
    .vidas        (vidas),
    .db_estado    (db_estado)
  );

  task automatic verifica(input string tag, input int obs, input int esp);
    n_comp++;
    if (obs != esp) begin
      n_erro++;
      $display("FAIL %s: obtido=%0d esperado=%0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  // Game rules: state numbers are the debug codes of the game description.
  task automatic modelo_passo(input bit r, ini, fe, fm, col, pau);
    if (r) begin
      m_est = 0; m_vid = NV; m_niv = 0;
    end else begin
      case (m_est)
        0, 7, 8: if (ini) begin m_est = 1; m_vid = NV; m_niv = 0; end
        1:  m_est = 3;
        3:  if (PAUSA_ON && pau) m_est = 11; else if (fe) m_est = 4;
        4:  m_est = 5;
        5:  m_est = col ? 9 : 6;
        6:  if (!fm) m_est = 3; else if (m_niv == NN - 1) m_est = 8; else m_est = 10;
        9:  begin m_est = (m_vid == 1) ? 7 : 1; m_vid = m_vid - 1; end
        10: begin m_est = 1; if (m_niv < NN - 1) m_niv = m_niv + 1; end
        11: if (pau) m_est = 3;
        default: m_est = 0;
      endcase
    end
  endtask

  task automatic confere_modelo();
    verifica("zeraPosicoes", zeraPosicoes, int'(m_est inside {0, 1}));
    verifica("zeraT",        zeraT,        int'(m_est inside {0, 1, 6, 9, 10}));
    verifica("contaT",       contaT,       int'(m_est == 3));
    verifica("desloca",      desloca,      int'(m_est == 4));
    verifica("venceu",       venceu,       int'(m_est == 8));
    verifica("perdeu",       perdeu,       int'(m_est == 7));
    verifica("db_estado",    db_estado,    m_est);
    verifica("vidas",        vidas,        m_vid);
    verifica("nivel",        nivel,        m_niv);
  endtask

  // One clock: drive inputs, let the edge happen, then check at the falling edge.
  task automatic ciclo(input bit r, ini = 0, fe = 0, fm = 0, col = 0, pau = 0);
    reset = r; iniciar = ini; fim_espera = fe; fim_mapa = fm; colisao = col; pausar = pau;
    @(posedge clock);
    modelo_passo(r, ini, fe, fm, col, pau);
    @(negedge clock);
    confere_modelo();
  endtask

  // From ESPERA: timer expiry, shift, verdict, then the PROXIMO/PERDE_VIDA exit.
  task automatic passo(input bit fm, input bit col);
    ciclo(0, 0, 1, 0, 0, 0);
    ciclo(0, 0, 0, 0, 0, 0);
    ciclo(0, 0, 0, 0, col, 0);
    ciclo(0, 0, 0, fm, 0, 0);
  endtask

  initial begin
    m_est = 0; m_vid = NV; m_niv = 0;

    ciclo(1);
    verifica("rst_db", db_estado, 0);
    verifica("rst_vidas", vidas, 3);
    verifica("rst_nivel", nivel, 0);
    verifica("rst_zeraPos", zeraPosicoes, 1);

    // Clear both levels without collision.
    ciclo(0, 1);
    ciclo(0);
    passo(0, 0);
    passo(0, 0);
    passo(1, 0);
    verifica("t1_prox_nivel_db", db_estado, 10);
    verifica("t1_nivel_antes", nivel, 0);
    ciclo(0);
    verifica("t1_nivel_depois", nivel, 1);
    verifica("t1_prep_db", db_estado, 1);
    ciclo(0);
    passo(1, 0);
    verifica("t1_venceu", venceu, 1);
    verifica("t1_vitoria_db", db_estado, 8);

    // Three collisions lose the game.
    ciclo(0, 1);
    ciclo(0);
    passo(0, 1);
    verifica("t2_vidas2", vidas, 2);
    verifica("t2_prep1", db_estado, 1);
    ciclo(0);
    passo(0, 1);
    verifica("t2_vidas1", vidas, 1);
    ciclo(0);
    passo(0, 1);
    verifica("t2_perdeu", perdeu, 1);
    verifica("t2_vidas0", vidas, 0);
    verifica("t2_derrota_db", db_estado, 7);

    // Restart from DERROTA.
    ciclo(0, 1);
    verifica("t3_db", db_estado, 1);
    verifica("t3_vidas", vidas, 3);
    verifica("t3_nivel", nivel, 0);
    verifica("t3_zeraPos", zeraPosicoes, 1);

    // Reset in DESLOCAMENTO after a lost life reloads the counters.
    ciclo(0);
    passo(0, 1);
    ciclo(0);
    ciclo(0, 0, 1);
    verifica("t4_desloca", desloca, 1);
    ciclo(1, 0, 1);
    verifica("t4_db", db_estado, 0);
    verifica("t4_desloca0", desloca, 0);
    verifica("t4_contaT0", contaT, 0);
    verifica("t4_vidas", vidas, 3);

    // Pause toggle with the timer expiry held high.
    ciclo(0, 1);
    ciclo(0);
    ciclo(0, 0, 0, 0, 0, 1);
    verifica("t5_estado", db_estado, PAUSA_ON ? 11 : 3);
`ifdef PAUSA_EN
    ciclo(0, 0, 1);
    verifica("t5_pausa_hold", db_estado, 11);
    verifica("t5_contaT0", contaT, 0);
    ciclo(0, 0, 0, 0, 0, 1);
    verifica("t5_retoma", db_estado, 3);
    verifica("t5_contaT1", contaT, 1);
`else
    ciclo(0, 0, 0, 0, 0, 1);
    verifica("t5_sem_pausa", db_estado, 3);
`endif

    // pausar and fim_espera together.
    ciclo(1);
    ciclo(0, 1);
    ciclo(0);
    ciclo(0, 0, 1, 0, 0, 1);
    verifica("t6_prioridade", db_estado, PAUSA_ON ? 11 : 4);

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      ciclo($urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule
